// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine dispense path.
//   dispense_state_e : dispense controller FSM states
//   sale_evt_t       : one buffered sale event {soda, change in nickels}
//   DIME_NICKELS / NICKEL_NICKELS : coin values expressed in nickels
//   is_sale_event()  : true when an input sample carries something to dispense
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VEND   = 3'd1,
        ST_CHANGE = 3'd2,
        ST_GAP    = 3'd3,
        ST_FAULT  = 3'd4
    } dispense_state_e;

    typedef struct packed {
        logic       soda;
        logic [2:0] change;
    } sale_evt_t;

    localparam logic [2:0] DIME_NICKELS   = 3'd2;
    localparam logic [2:0] NICKEL_NICKELS = 3'd1;

    function automatic logic is_sale_event(input sale_evt_t evt);
        return evt.soda | (evt.change != 3'd0);
    endfunction

endpackage

// File: rtl/vm_event_fifo.sv
// Synchronous FIFO holding sale events between capture and the dispense FSM.
// Head entry is visible on pop_data_o while not empty (show-ahead).
//   clk_i_tb, rst_ni_tb : clock, async active-low reset
//   push_i/push_data_i  : write one entry (ignored when full unless popping too)
//   pop_i/pop_data_o    : remove head entry (ignored when empty)
//   full_o, empty_o     : occupancy flags
//   count_o             : number of stored entries
module vm_event_fifo
    import vm_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i_tb,
    input  logic          rst_ni_tb,
    input  logic          push_i,
    input  sale_evt_t     push_data_i,
    input  logic          pop_i,
    output sale_evt_t     pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    sale_evt_t      mem_q [DEPTH];
    sale_evt_t      mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_s, pop_s;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == {CW{1'b0}});
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; a push into a full
    // FIFO is only accepted when the same edge pops.
    always_comb begin
        push_s   = push_i & (~full_o | pop_i);
        pop_s    = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // FIFO state registers.
    always_ff @(posedge clk_i_tb or negedge rst_ni_tb) begin
        if (!rst_ni_tb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vm_dispense_ctrl.sv
// Dispense controller: buffers soda/change events from the vending core,
// runs the vend-motor handshake per soda and pays change as dime/nickel
// eject pulses (greedy dimes, then at most one nickel). All outputs registered.
//   clk_i_tb, rst_ni_tb : clock, async active-low reset
//   soda_i, change_i    : sale event input (change in nickels)
//   vend_ack_i          : motor done, sampled only while vending
//   hopper_ready_i      : hopper accepts an eject pulse this cycle
//   vend_req_o          : soda request, held until ack or timeout
//   dime_eject_o, nickel_eject_o : one-cycle coin eject pulses
//   busy_o              : FSM active or events queued
//   overflow_o, fault_o : sticky dropped-event / vend-timeout flags
module vm_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned EJECT_GAP    = 2,
    parameter int unsigned VEND_TIMEOUT = 64
) (
    input  logic       clk_i_tb,
    input  logic       rst_ni_tb,
    input  logic       soda_i,
    input  logic [2:0] change_i,
    input  logic       vend_ack_i,
    input  logic       hopper_ready_i,
    output logic       vend_req_o,
    output logic       dime_eject_o,
    output logic       nickel_eject_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       fault_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(VEND_TIMEOUT);
    localparam int unsigned GW = (EJECT_GAP > 0) ? $clog2(EJECT_GAP + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(VEND_TIMEOUT - 1);
    // Only used when EJECT_GAP > 0; the GAP state is unreachable otherwise.
    localparam logic [GW-1:0] GAP_LAST = GW'(EJECT_GAP - 1);

    dispense_state_e state_q, state_d;
    logic [2:0]      rem_q, rem_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            vend_req_q, vend_req_d;
    logic            dime_q, dime_d;
    logic            nickel_q, nickel_d;
    logic            busy_q, busy_d;
    logic            overflow_q, overflow_d;
    logic            fault_q, fault_d;

    sale_evt_t       evt_s, fifo_head_s;
    logic            evt_valid_s, push_s, pop_s, drop_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s, fifo_count_next_s;
    logic            dime_fire_s, nickel_fire_s, timeout_s;

    vm_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i_tb    (clk_i_tb),
        .rst_ni_tb   (rst_ni_tb),
        .push_i      (push_s),
        .push_data_i (evt_s),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    // Event capture runs in every state; a full FIFO only drops when the
    // same edge does not free a slot.
    always_comb begin
        evt_s             = '{soda: soda_i, change: change_i};
        evt_valid_s       = is_sale_event(evt_s);
        pop_s             = (state_q == ST_IDLE) & ~fifo_empty_s;
        push_s            = evt_valid_s & (~fifo_full_s | pop_s);
        drop_s            = evt_valid_s & fifo_full_s & ~pop_s;
        fifo_count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end

    // Next-state logic: FSM, change remainder, timeout and gap counters.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        dime_fire_s   = 1'b0;
        nickel_fire_s = 1'b0;
        timeout_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                gap_d = '0;
                if (!fifo_empty_s) begin
                    rem_d   = fifo_head_s.change;
                    state_d = fifo_head_s.soda ? ST_VEND : ST_CHANGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VEND: begin
                // Ack on the last allowed cycle still counts as success.
                if (vend_ack_i) begin
                    tmo_d   = '0;
                    state_d = (rem_q != 3'd0) ? ST_CHANGE : ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHANGE: begin
                gap_d = '0;
                if (rem_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else if (!hopper_ready_i) begin
                    state_d = ST_CHANGE;
                end else begin
                    // rem_q >= 2 guards the dime subtract, so rem never wraps.
                    if (rem_q >= DIME_NICKELS) begin
                        dime_fire_s = 1'b1;
                        rem_d       = rem_q - DIME_NICKELS;
                    end else begin
                        nickel_fire_s = 1'b1;
                        rem_d         = rem_q - NICKEL_NICKELS;
                    end
                    if (EJECT_GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = (rem_d != 3'd0) ? ST_CHANGE : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (rem_q != 3'd0) ? ST_CHANGE : ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values; vend_req follows the next state so the request
    // appears on the same edge that enters VEND.
    always_comb begin
        vend_req_d = (state_d == ST_VEND);
        dime_d     = dime_fire_s;
        nickel_d   = nickel_fire_s;
        fault_d    = fault_q | timeout_s;
        overflow_d = overflow_q | drop_s;
        busy_d     = (state_d != ST_IDLE) | (fifo_count_next_s != {CW{1'b0}});
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk_i_tb or negedge rst_ni_tb) begin
        if (!rst_ni_tb) begin
            state_q <= ST_IDLE;
            rem_q   <= 3'd0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i_tb or negedge rst_ni_tb) begin
        if (!rst_ni_tb) begin
            vend_req_q <= 1'b0;
            dime_q     <= 1'b0;
            nickel_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            vend_req_q <= vend_req_d;
            dime_q     <= dime_d;
            nickel_q   <= nickel_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
        end
    end

    assign vend_req_o     = vend_req_q;
    assign dime_eject_o   = dime_q;
    assign nickel_eject_o = nickel_q;
    assign busy_o         = busy_q;
    assign overflow_o     = overflow_q;
    assign fault_o        = fault_q;

endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Scoreboard bench for vm_dispense_ctrl: stimulus pushes the expected
// output events (vend request, dime, nickel) into a queue; a monitor pops
// and compares whenever the DUT presents one of them.
module tb_vm_dispense_ctrl;

    localparam int EV_VEND = 1;
    localparam int EV_DIME = 2;
    localparam int EV_NICK = 3;

    logic       clk_i_tb = 1'b0;
    logic       rst_ni_tb = 1'b0;
    logic       soda_i = 1'b0;
    logic [2:0] change_i = 3'd0;
    logic       vend_ack_i = 1'b0;
    logic       hopper_ready_i = 1'b0;
    logic       vend_req_o, dime_eject_o, nickel_eject_o;
    logic       busy_o, overflow_o, fault_o;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int pulse_cyc[$];
    int cyc = 0;
    int rises = 0;
    int run_len = 0;
    int last_run = 0;
    logic vend_prev = 1'b0;

    vm_dispense_ctrl dut (
        .clk_i_tb       (clk_i_tb),
        .rst_ni_tb      (rst_ni_tb),
        .soda_i         (soda_i),
        .change_i       (change_i),
        .vend_ack_i     (vend_ack_i),
        .hopper_ready_i (hopper_ready_i),
        .vend_req_o     (vend_req_o),
        .dime_eject_o   (dime_eject_o),
        .nickel_eject_o (nickel_eject_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .fault_o        (fault_o)
    );

    always #5 clk_i_tb = ~clk_i_tb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_evt(input int got);
        int want;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %0d expected none at cycle %0d", got, cyc);
        end else begin
            want = exp_q.pop_front();
            if (want != got) begin
                miscompares++;
                $display("FAIL event_order: got %0d expected %0d at cycle %0d", got, want, cyc);
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk_i_tb) begin
        cyc++;
        if (rst_ni_tb) begin
            if (vend_req_o && !vend_prev) begin
                rises++;
                mon_evt(EV_VEND);
            end
            if (vend_req_o) begin
                run_len++;
            end else if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (dime_eject_o || nickel_eject_o) begin
                pulse_cyc.push_back(cyc);
                check("one_hot_eject", {31'd0, dime_eject_o & nickel_eject_o}, 32'd0);
                if (dime_eject_o) mon_evt(EV_DIME);
                if (nickel_eject_o) mon_evt(EV_NICK);
            end
            vend_prev = vend_req_o;
        end else begin
            vend_prev = 1'b0;
            run_len   = 0;
        end
    end

    // Step to 1 time unit after the next rising edge (input drive point).
    task automatic step(input int n);
        repeat (n) @(posedge clk_i_tb);
        #1;
    endtask

    // Step to just after the next falling edge (check point, after monitor).
    task automatic at_neg();
        @(negedge clk_i_tb);
        #1;
    endtask

    task automatic send(input logic s, input logic [2:0] c);
        soda_i   = s;
        change_i = c;
        step(1);
        soda_i   = 1'b0;
        change_i = 3'd0;
    endtask

    task automatic wait_vend(input string name, input int budget);
        int n = 0;
        while (!vend_req_o && n < budget) begin
            at_neg();
            n++;
        end
        check(name, {31'd0, vend_req_o}, 32'd1);
    endtask

    initial begin
        int snap;
        // Reset state
        step(3);
        at_neg();
        check("reset_outputs", {26'd0, vend_req_o, dime_eject_o, nickel_eject_o,
                                busy_o, overflow_o, fault_o}, 32'd0);
        step(1);
        rst_ni_tb = 1'b1;
        step(2);

        // 1: soda only, ack three cycles after request
        exp_q.push_back(EV_VEND);
        send(1'b1, 3'd0);
        wait_vend("t1_vend_seen", 10);
        step(3);
        vend_ack_i = 1'b1;
        step(1);
        vend_ack_i = 1'b0;
        step(3);
        at_neg();
        check("t1_busy_after", {31'd0, busy_o}, 32'd0);
        check("t1_req_low", {31'd0, vend_req_o}, 32'd0);
        check("t1_no_ejects", pulse_cyc.size(), 32'd0);
        check("t1_all_seen", exp_q.size(), 32'd0);

        // 2: soda + 25c with hopper ready: dime, dime, nickel, 2-cycle gaps
        hopper_ready_i = 1'b1;
        pulse_cyc.delete();
        exp_q.push_back(EV_VEND);
        exp_q.push_back(EV_DIME);
        exp_q.push_back(EV_DIME);
        exp_q.push_back(EV_NICK);
        send(1'b1, 3'd5);
        wait_vend("t2_vend_seen", 10);
        vend_ack_i = 1'b1;
        step(1);
        vend_ack_i = 1'b0;
        step(20);
        at_neg();
        check("t2_pulse_count", pulse_cyc.size(), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("t2_gap_1", pulse_cyc[1] - pulse_cyc[0], 32'd3);
            check("t2_gap_2", pulse_cyc[2] - pulse_cyc[1], 32'd3);
        end
        check("t2_all_seen", exp_q.size(), 32'd0);
        check("t2_busy_after", {31'd0, busy_o}, 32'd0);

        // 3: 15c change only, hopper stalled for 10 cycles
        hopper_ready_i = 1'b0;
        pulse_cyc.delete();
        exp_q.push_back(EV_DIME);
        exp_q.push_back(EV_NICK);
        send(1'b0, 3'd3);
        step(10);
        check("t3_no_eject_stalled", pulse_cyc.size(), 32'd0);
        check("t3_busy_stalled", {31'd0, busy_o}, 32'd1);
        hopper_ready_i = 1'b1;
        step(15);
        at_neg();
        check("t3_pulse_count", pulse_cyc.size(), 32'd2);
        check("t3_all_seen", exp_q.size(), 32'd0);

        // 4: stall in VEND, burst of 5 sodas: 4 queue, 1 dropped
        exp_q.push_back(EV_VEND);
        send(1'b1, 3'd0);
        wait_vend("t4_stall_vend", 10);
        check("t4_overflow_before", {31'd0, overflow_o}, 32'd0);
        soda_i = 1'b1;
        step(5);
        soda_i = 1'b0;
        step(1);
        at_neg();
        check("t4_overflow_set", {31'd0, overflow_o}, 32'd1);
        rises = 0;
        repeat (4) exp_q.push_back(EV_VEND);
        vend_ack_i = 1'b1;
        step(25);
        vend_ack_i = 1'b0;
        step(3);
        at_neg();
        check("t4_queued_vends", rises, 32'd4);
        check("t4_all_seen", exp_q.size(), 32'd0);
        check("t4_busy_after", {31'd0, busy_o}, 32'd0);
        check("t4_no_fault", {31'd0, fault_o}, 32'd0);

        // 5: vend timeout -> fault, later events ignored
        exp_q.push_back(EV_VEND);
        send(1'b1, 3'd0);
        step(80);
        at_neg();
        check("t5_req_cycles", last_run, 32'd64);
        check("t5_fault_set", {31'd0, fault_o}, 32'd1);
        check("t5_req_low", {31'd0, vend_req_o}, 32'd0);
        snap = rises;
        pulse_cyc.delete();
        send(1'b1, 3'd2);
        step(10);
        at_neg();
        check("t5_no_vend_in_fault", rises - snap, 32'd0);
        check("t5_no_eject_in_fault", pulse_cyc.size(), 32'd0);
        check("t5_all_seen", exp_q.size(), 32'd0);

        // 6: reset while sitting in CHANGE with 20c left and a soda queued
        rst_ni_tb = 1'b0;
        step(2);
        rst_ni_tb = 1'b1;
        step(1);
        check("t6_fault_cleared", {31'd0, fault_o}, 32'd0);
        hopper_ready_i = 1'b1;
        pulse_cyc.delete();
        exp_q.push_back(EV_DIME);
        send(1'b0, 3'd6);
        send(1'b1, 3'd0);
        snap = 0;
        while (pulse_cyc.size() == 0 && snap < 10) begin
            at_neg();
            snap++;
        end
        hopper_ready_i = 1'b0;
        check("t6_first_dime", pulse_cyc.size(), 32'd1);
        step(5);
        at_neg();
        check("t6_busy_before_reset", {31'd0, busy_o}, 32'd1);
        #1 rst_ni_tb = 1'b0;
        #1;
        check("t6_outputs_cleared", {26'd0, vend_req_o, dime_eject_o, nickel_eject_o,
                                     busy_o, overflow_o, fault_o}, 32'd0);
        exp_q.delete();
        step(2);
        rst_ni_tb = 1'b1;
        hopper_ready_i = 1'b1;
        snap = rises;
        step(20);
        at_neg();
        check("t6_no_eject_after", pulse_cyc.size(), 32'd1);
        check("t6_no_vend_after", rises - snap, 32'd0);
        check("t6_fifo_empty", {31'd0, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
